// File: rtl/seq_chunk_adder_if.sv
// Operand/result bus for seq_chunk_adder.
//   master: requester side (drives start/sub/a/b/cin, observes busy/done/sum/cout)
//   slave : adder side
// With SEQ_ADDER_OVF_EN defined the bus also carries the signed overflow flag ovf.
interface seq_chunk_adder_if #(
  parameter int unsigned WIDTH = 8
) ();
  logic             start;
  logic             sub;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;
`ifdef SEQ_ADDER_OVF_EN
  logic             ovf;
`endif

  modport master (
    output start, sub, a, b, cin,
    input  busy, done, sum, cout
`ifdef SEQ_ADDER_OVF_EN
    , input ovf
`endif
  );

  modport slave (
    input  start, sub, a, b, cin,
    output busy, done, sum, cout
`ifdef SEQ_ADDER_OVF_EN
    , output ovf
`endif
  );
endinterface

// File: rtl/seq_chunk_adder.sv
// Multi-cycle adder/subtractor: adds two WIDTH-bit operands CHUNK bits per
// clock, LSB chunk first, through an internal carry register.
//   clk  : rising-edge clock
//   rst  : synchronous active-high reset
//   bus  : seq_chunk_adder_if.slave (start/sub/a/b/cin in, busy/done/sum/cout out)
// Optional macro SEQ_ADDER_OVF_EN adds the registered signed overflow bus.ovf.
module seq_chunk_adder #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CHUNK = 1
) (
  input  logic           clk,
  input  logic           rst,
  seq_chunk_adder_if.slave bus
);

  localparam int unsigned STEPS = WIDTH / CHUNK;
  localparam int unsigned CW    = (STEPS > 1) ? $clog2(STEPS) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       state;
  logic [1:0]       state_nx;

  // Operands shift right one chunk per step so the active chunk is always at the bottom.
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic [WIDTH-1:0] res;
  logic             carry;
  logic [CW-1:0]    step;

  logic [CHUNK:0]   chunk_sum;
  logic [WIDTH-1:0] res_nx;
  logic             last_step;

  logic             busy_q;
  logic             done_q;
  logic [WIDTH-1:0] sum_q;
  logic             cout_q;
`ifdef SEQ_ADDER_OVF_EN
  logic             ovf_q;
  logic             ovf_nx;
`endif

  // Chunk adder, result shift-in and next-state decode
  always_comb begin
    state_nx  = state;
    last_step = (step == CW'(STEPS - 1));
    chunk_sum = (CHUNK + 1)'(op_a[CHUNK-1:0]) + (CHUNK + 1)'(op_b[CHUNK-1:0])
              + (CHUNK + 1)'(carry);
    // New chunk enters at the top; after STEPS shifts it lands at [k*CHUNK +: CHUNK].
    res_nx    = (res >> CHUNK) | (WIDTH'(chunk_sum[CHUNK-1:0]) << (WIDTH - CHUNK));
    case (state)
      S_IDLE:  if (bus.start) state_nx = S_RUN;
      S_RUN:   if (last_step) state_nx = S_DONE;
      S_DONE:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

`ifdef SEQ_ADDER_OVF_EN
  // Carry into the MSB is recovered as sum^a^b at the top bit of the final chunk.
  always_comb begin
    ovf_nx = chunk_sum[CHUNK] ^ chunk_sum[CHUNK-1] ^ op_a[CHUNK-1] ^ op_b[CHUNK-1];
  end
`endif

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  // Datapath and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      op_a   <= '0;
      op_b   <= '0;
      res    <= '0;
      carry  <= 1'b0;
      step   <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      sum_q  <= '0;
      cout_q <= 1'b0;
`ifdef SEQ_ADDER_OVF_EN
      ovf_q  <= 1'b0;
`endif
    end else begin
      busy_q <= (state_nx == S_RUN);
      done_q <= (state_nx == S_DONE);
      case (state)
        S_IDLE: begin
          if (bus.start) begin
            op_a  <= bus.a;
            op_b  <= bus.sub ? ~bus.b : bus.b;
            // Subtract is a + ~b + 1, so cin is forced to 1.
            carry <= bus.sub | bus.cin;
            step  <= '0;
          end
        end
        S_RUN: begin
          op_a  <= op_a >> CHUNK;
          op_b  <= op_b >> CHUNK;
          carry <= chunk_sum[CHUNK];
          res   <= res_nx;
          step  <= step + CW'(1);
          if (last_step) begin
            sum_q  <= res_nx;
            cout_q <= chunk_sum[CHUNK];
`ifdef SEQ_ADDER_OVF_EN
            ovf_q  <= ovf_nx;
`endif
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.sum  = sum_q;
  assign bus.cout = cout_q;
`ifdef SEQ_ADDER_OVF_EN
  assign bus.ovf  = ovf_q;
`endif

endmodule

// File: tb/tb_seq_chunk_adder.sv
// Bench for seq_chunk_adder: three instances (CHUNK = 1, 2, 4; WIDTH = 8),
// table-driven vectors plus hand-written corner sequences, results checked by
// a per-instance expectation queue popped on each done pulse.
module tb_seq_chunk_adder;

  localparam int unsigned WIDTH = 8;

  typedef struct {
    logic [7:0] sum;
    logic       cout;
    logic       ovf;
  } exp_t;

  typedef struct {
    int         w;
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic       sub;
    logic [7:0] sum;
    logic       cout;
    logic       ovf;
  } vec_t;

  logic clk = 1'b0;
  logic rst1, rst2, rst4;

  always #5 clk = ~clk;

  seq_chunk_adder_if #(.WIDTH(WIDTH)) if1 ();
  seq_chunk_adder_if #(.WIDTH(WIDTH)) if2 ();
  seq_chunk_adder_if #(.WIDTH(WIDTH)) if4 ();

  seq_chunk_adder #(.WIDTH(WIDTH), .CHUNK(1)) u_c1 (.clk(clk), .rst(rst1), .bus(if1));
  seq_chunk_adder #(.WIDTH(WIDTH), .CHUNK(2)) u_c2 (.clk(clk), .rst(rst2), .bus(if2));
  seq_chunk_adder #(.WIDTH(WIDTH), .CHUNK(4)) u_c4 (.clk(clk), .rst(rst4), .bus(if4));

  int checks = 0;
  int errors = 0;

  exp_t q1[$];
  exp_t q2[$];
  exp_t q4[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic exp_t model(input logic [7:0] a, input logic [7:0] b,
                                 input logic cin, input logic sub);
    exp_t       e;
    logic [7:0] bb;
    logic [8:0] r;
    bb     = sub ? ~b : b;
    r      = {1'b0, a} + {1'b0, bb} + 9'(sub ? 1'b1 : cin);
    e.sum  = r[7:0];
    e.cout = r[8];
    e.ovf  = (a[7] == bb[7]) && (r[7] != a[7]);
    return e;
  endfunction

  function automatic logic busy_of(input int w);
    case (w)
      1:       return if1.busy;
      2:       return if2.busy;
      default: return if4.busy;
    endcase
  endfunction

  function automatic logic done_of(input int w);
    case (w)
      1:       return if1.done;
      2:       return if2.done;
      default: return if4.done;
    endcase
  endfunction

  function automatic logic [7:0] sum_of(input int w);
    case (w)
      1:       return if1.sum;
      2:       return if2.sum;
      default: return if4.sum;
    endcase
  endfunction

  function automatic logic cout_of(input int w);
    case (w)
      1:       return if1.cout;
      2:       return if2.cout;
      default: return if4.cout;
    endcase
  endfunction

  task automatic drive(input int w, input logic st, input logic [7:0] a, input logic [7:0] b,
                       input logic cin, input logic sub);
    case (w)
      1: begin if1.start = st; if1.a = a; if1.b = b; if1.cin = cin; if1.sub = sub; end
      2: begin if2.start = st; if2.a = a; if2.b = b; if2.cin = cin; if2.sub = sub; end
      default: begin if4.start = st; if4.a = a; if4.b = b; if4.cin = cin; if4.sub = sub; end
    endcase
  endtask

  task automatic push(input int w, input exp_t e);
    case (w)
      1:       q1.push_back(e);
      2:       q2.push_back(e);
      default: q4.push_back(e);
    endcase
  endtask

  task automatic step_clk();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input int w);
    int n;
    n = 0;
    while ((busy_of(w) || done_of(w)) && n < 100) begin
      step_clk();
      n++;
    end
    if (n >= 100) begin
      checks++;
      errors++;
      $display("FAIL wait_idle_dut%0d timeout actual=busy expected=idle", w);
    end
  endtask

  task automatic wait_done(input int w);
    int n;
    n = 0;
    while (!done_of(w) && n < 100) begin
      step_clk();
      n++;
    end
    if (n >= 100) begin
      checks++;
      errors++;
      $display("FAIL wait_done_dut%0d timeout actual=no_done expected=done", w);
    end
  endtask

  // Start one operation; returns just after the accepting edge with start dropped
  // and the operand inputs scrambled.
  task automatic issue(input int w, input logic [7:0] a, input logic [7:0] b, input logic cin,
                       input logic sub, input bit do_push, input exp_t e);
    wait_idle(w);
    drive(w, 1'b1, a, b, cin, sub);
    step_clk();
    drive(w, 1'b0, 8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom));
    if (do_push) push(w, e);
  endtask

  task automatic got(input int w, input logic [7:0] s, input logic c,
                     output exp_t e, output bit ok);
    int sz;
    case (w)
      1:       sz = q1.size();
      2:       sz = q2.size();
      default: sz = q4.size();
    endcase
    ok = 1'b0;
    e  = '{8'h00, 1'b0, 1'b0};
    if (sz == 0) begin
      checks++;
      errors++;
      $display("FAIL unexpected_done_dut%0d actual=done expected=no_done", w);
    end else begin
      case (w)
        1:       e = q1.pop_front();
        2:       e = q2.pop_front();
        default: e = q4.pop_front();
      endcase
      ok = 1'b1;
      check($sformatf("dut%0d_sum", w), 32'(s), 32'(e.sum));
      check($sformatf("dut%0d_cout", w), 32'(c), 32'(e.cout));
    end
  endtask

  always @(negedge clk) begin : mon1
    exp_t e;
    bit   ok;
    if (if1.done) begin
      got(1, if1.sum, if1.cout, e, ok);
`ifdef SEQ_ADDER_OVF_EN
      if (ok) check("dut1_ovf", 32'(if1.ovf), 32'(e.ovf));
`endif
    end
  end

  always @(negedge clk) begin : mon2
    exp_t e;
    bit   ok;
    if (if2.done) begin
      got(2, if2.sum, if2.cout, e, ok);
`ifdef SEQ_ADDER_OVF_EN
      if (ok) check("dut2_ovf", 32'(if2.ovf), 32'(e.ovf));
`endif
    end
  end

  always @(negedge clk) begin : mon4
    exp_t e;
    bit   ok;
    if (if4.done) begin
      got(4, if4.sum, if4.cout, e, ok);
`ifdef SEQ_ADDER_OVF_EN
      if (ok) check("dut4_ovf", 32'(if4.ovf), 32'(e.ovf));
`endif
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=running expected=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    vec_t tbl [0:10];
    exp_t e;
    exp_t e1;
    exp_t e2;
    int   n;
    int   busy_cnt;
    int   done_cnt;

    tbl[0]  = '{1, 8'h5A, 8'h3C, 1'b0, 1'b0, 8'h96, 1'b0, 1'b1};
    tbl[1]  = '{1, 8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0};
    tbl[2]  = '{1, 8'hFF, 8'h00, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0};
    tbl[3]  = '{1, 8'h00, 8'h00, 1'b1, 1'b0, 8'h01, 1'b0, 1'b0};
    tbl[4]  = '{1, 8'h10, 8'h01, 1'b0, 1'b1, 8'h0F, 1'b1, 1'b0};
    tbl[5]  = '{2, 8'h10, 8'h01, 1'b0, 1'b1, 8'h0F, 1'b1, 1'b0};
    tbl[6]  = '{2, 8'h00, 8'h01, 1'b1, 1'b1, 8'hFF, 1'b0, 1'b0};
    tbl[7]  = '{2, 8'hA5, 8'h5A, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0};
    tbl[8]  = '{4, 8'h80, 8'h80, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1};
    tbl[9]  = '{4, 8'h40, 8'h40, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1};
    tbl[10] = '{4, 8'h7F, 8'h01, 1'b0, 1'b1, 8'h7E, 1'b1, 1'b0};

    rst1 = 1'b1;
    rst2 = 1'b1;
    rst4 = 1'b1;
    for (int w = 1; w <= 4; w++) drive(w, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
    step_clk();
    step_clk();
    rst1 = 1'b0;
    rst2 = 1'b0;
    rst4 = 1'b0;

    // Reset state
    for (int w = 1; w <= 4; w++) begin
      if (w != 3) begin
        check($sformatf("rst_busy_dut%0d", w), 32'(busy_of(w)), 32'd0);
        check($sformatf("rst_done_dut%0d", w), 32'(done_of(w)), 32'd0);
        check($sformatf("rst_sum_dut%0d", w), 32'(sum_of(w)), 32'd0);
        check($sformatf("rst_cout_dut%0d", w), 32'(cout_of(w)), 32'd0);
      end
    end
`ifdef SEQ_ADDER_OVF_EN
    check("rst_ovf_dut4", 32'(if4.ovf), 32'd0);
`endif

    // Table vectors
    for (int i = 0; i <= 10; i++) begin
      e = '{tbl[i].sum, tbl[i].cout, tbl[i].ovf};
      issue(tbl[i].w, tbl[i].a, tbl[i].b, tbl[i].cin, tbl[i].sub, 1'b1, e);
      wait_done(tbl[i].w);
    end

    // Latency: busy for STEPS cycles, done STEPS edges after the accepting edge
    issue(1, 8'h5A, 8'h3C, 1'b0, 1'b0, 1'b1, model(8'h5A, 8'h3C, 1'b0, 1'b0));
    n = 0;
    busy_cnt = 0;
    while (n < 40) begin
      if (busy_of(1)) busy_cnt++;
      if (done_of(1)) break;
      step_clk();
      n++;
    end
    check("c1_done_latency", 32'(n), 32'd8);
    check("c1_busy_cycles", 32'(busy_cnt), 32'd8);
    step_clk();
    check("c1_done_one_cycle", 32'(done_of(1)), 32'd0);

    issue(4, 8'h80, 8'h80, 1'b0, 1'b0, 1'b1, model(8'h80, 8'h80, 1'b0, 1'b0));
    n = 0;
    while (n < 40 && !done_of(4)) begin
      step_clk();
      n++;
    end
    check("c4_done_latency", 32'(n), 32'd2);

    // Start during RUN is ignored
    issue(1, 8'h01, 8'h01, 1'b0, 1'b0, 1'b1, '{8'h02, 1'b0, 1'b0});
    step_clk();
    step_clk();
    step_clk();
    drive(1, 1'b1, 8'hFF, 8'hFF, 1'b0, 1'b0);
    step_clk();
    drive(1, 1'b0, 8'hFF, 8'hFF, 1'b0, 1'b0);
    wait_done(1);
    step_clk();
    check("ign_done_low", 32'(done_of(1)), 32'd0);
    check("ign_no_queue", 32'(busy_of(1)), 32'd0);
    step_clk();
    check("ign_still_idle", 32'(busy_of(1)), 32'd0);

    // Reset mid-RUN aborts the operation
    issue(1, 8'h12, 8'h34, 1'b0, 1'b0, 1'b0, e);
    step_clk();
    step_clk();
    rst1 = 1'b1;
    step_clk();
    rst1 = 1'b0;
    check("abort_busy", 32'(busy_of(1)), 32'd0);
    check("abort_done", 32'(done_of(1)), 32'd0);
    check("abort_sum", 32'(sum_of(1)), 32'd0);
    check("abort_cout", 32'(cout_of(1)), 32'd0);
    done_cnt = 0;
    for (int i = 0; i < 15; i++) begin
      if (done_of(1)) done_cnt++;
      step_clk();
    end
    check("abort_no_done", 32'(done_cnt), 32'd0);
    issue(1, 8'h12, 8'h34, 1'b0, 1'b0, 1'b1, '{8'h46, 1'b0, 1'b0});
    wait_done(1);
    wait_idle(1);

    // Start together with reset is ignored
    rst1 = 1'b1;
    drive(1, 1'b1, 8'h11, 8'h22, 1'b0, 1'b0);
    step_clk();
    rst1 = 1'b0;
    drive(1, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
    check("rst_start_busy0", 32'(busy_of(1)), 32'd0);
    step_clk();
    check("rst_start_busy1", 32'(busy_of(1)), 32'd0);

    // Result holds through IDLE and the next RUN
    e1 = model(8'hC3, 8'h7D, 1'b1, 1'b0);
    issue(2, 8'hC3, 8'h7D, 1'b1, 1'b0, 1'b1, e1);
    wait_done(2);
    wait_idle(2);
    check("hold_idle_sum", 32'(sum_of(2)), 32'(e1.sum));
    e2 = model(8'h3E, 8'hA1, 1'b0, 1'b1);
    issue(2, 8'h3E, 8'hA1, 1'b0, 1'b1, 1'b1, e2);
    step_clk();
    check("hold_run_busy", 32'(busy_of(2)), 32'd1);
    check("hold_run_sum", 32'(sum_of(2)), 32'(e1.sum));
    check("hold_run_cout", 32'(cout_of(2)), 32'(e1.cout));
    wait_done(2);

    // Random operations, back to back
    for (int i = 0; i < 24; i++) begin
      logic [7:0] ra, rb;
      logic       rc, rs;
      int         w;
      ra = 8'($urandom);
      rb = 8'($urandom);
      rc = 1'($urandom);
      rs = 1'($urandom);
      w  = (i % 3 == 0) ? 1 : ((i % 3 == 1) ? 2 : 4);
      issue(w, ra, rb, rc, rs, 1'b1, model(ra, rb, rc, rs));
      wait_done(w);
    end

    wait_idle(1);
    wait_idle(2);
    wait_idle(4);
    step_clk();
    step_clk();
    check("q1_drained", 32'(q1.size()), 32'd0);
    check("q2_drained", 32'(q2.size()), 32'd0);
    check("q4_drained", 32'(q4.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/seq_chunk_adder.md
Name: seq_chunk_adder

Overview:
Parametrised multi-cycle adder/subtractor, successor to the single-bit full adder cell. Adds two WIDTH-bit operands CHUNK bits per clock, LSB chunk first, through an internal carry register. Uses a start/busy/done handshake, so wide adds can share one small adder slice in area-constrained datapaths.

Parameters:
WIDTH, 8, operand and result width in bits; must be a multiple of CHUNK.
CHUNK, 1, bits added per cycle; 1 gives a bit-serial adder, WIDTH gives a single-step add.
(derived) STEPS = WIDTH/CHUNK, number of compute cycles.

Ports:
clk  input  1  clock, rising edge.
rst  input  1  synchronous reset, active-high.
start  input  1  request a new operation; sampled only in IDLE.
sub  input  1  0 = a+b+cin; 1 = a-b (two's complement; cin ignored).
a  input  WIDTH  operand A; captured on the accepted start.
b  input  WIDTH  operand B; captured on the accepted start.
cin  input  1  carry in for add; captured on the accepted start.
busy  output  1  high while computing (RUN state).
done  output  1  one-cycle pulse: sum/cout are valid.
sum  output  WIDTH  registered result.
cout  output  1  carry out; for sub, 1 = no borrow.

Behaviour:
- Reset: state=IDLE; busy=0, done=0, sum=0, cout=0. Internal operand, carry and step registers are cleared.
- States: IDLE -> RUN -> DONE -> IDLE.
- IDLE, edge with start=1:
  - Capture a, and b (as ~b when sub=1).
  - Carry register = (sub ? 1 : cin).
  - Step counter = 0; go to RUN.
- RUN, each edge:
  - Add chunk k of A, chunk k of B' and the carry register.
  - Write the CHUNK-bit result into internal result bits [k*CHUNK +: CHUNK].
  - Carry register takes the chunk carry; k increments.
  - On the edge that processes k = STEPS-1, go to DONE.
  - On that same edge, load sum from the full internal result and load cout from the final carry.
- DONE: done=1 for exactly one cycle; the next edge returns to IDLE.
- busy=1 exactly in RUN. Accepted start at edge E gives busy high over cycles E+1..E+STEPS and done high over cycle E+STEPS+1. Total latency is STEPS+1 edges.
- sum/cout change only when entering DONE. They hold their value through IDLE and any later RUN until the next DONE.
- start in RUN or DONE is ignored: no queuing and no effect on the operation in flight.
- start in IDLE in the cycle done deasserts is accepted normally, so back-to-back operations run at a rate of STEPS+2 cycles.
- Operand inputs may change freely after capture without affecting the result.
- Step counter width is clog2(STEPS) with a minimum of 1 bit. With CHUNK=WIDTH, RUN lasts one cycle.
- rst has priority over all other events. Reset mid-RUN aborts: no done pulse, sum/cout go to 0, state goes to IDLE.
- A start asserted together with rst is ignored.
- All arithmetic is unsigned modulo 2^WIDTH, with the carry out of bit WIDTH-1 reported on cout.

Optional Feature:
Macro: SEQ_ADDER_OVF_EN.
- Defined:
  - Adds output port ovf (1 bit, reset 0), the signed two's-complement overflow.
  - ovf = carry into MSB XOR carry out of MSB, computed on the final RUN step.
  - ovf is loaded with sum and cout, and held likewise.
- Undefined: the ovf port is absent and no overflow logic is built.

Test Plan:
- WIDTH=8, CHUNK=1, add 0x5A+0x3C, cin=0 -> sum=0x96, cout=0. busy high 8 cycles; done pulses once, 9 edges after start.
- WIDTH=8, CHUNK=1, add 0xFF+0x01, cin=0 -> sum=0x00, cout=1. Then 0xFF+0x00, cin=1 -> sum=0x00, cout=1.
- WIDTH=8, CHUNK=2, sub 0x10-0x01 -> sum=0x0F, cout=1. Then sub 0x00-0x01 with cin=1 (ignored) -> sum=0xFF, cout=0.
- WIDTH=8, CHUNK=1: start 0x01+0x01, then pulse start with a=0xFF, b=0xFF at RUN step 4 -> second start ignored; result sum=0x02, cout=0, single done pulse.
- WIDTH=8, CHUNK=1: start 0x12+0x34, assert rst at RUN step 3:
  - busy=0, done never pulses, sum=0, cout=0.
  - A following start of 0x12+0x34 -> sum=0x46.
- WIDTH=8, CHUNK=4, SEQ_ADDER_OVF_EN defined:
  - 0x80+0x80 -> sum=0x00, cout=1, ovf=1; done 3 edges after start.
  - 0x40+0x40 -> sum=0x80, cout=0, ovf=1.
  - 0x7F+0x01 with sub=1 -> sum=0x7E, ovf=0.
